scrambler_ctrl: RTL and testbench

- Sequences the 802.11a DATA-field scrambler for one PPDU per request.
- Loads the 7-bit seed, then feeds the scrambler input with bits in this order: 16 SERVICE zeros, PSDU bits (LSB first per byte), 6 tail zeros, then pad zeros up to a whole number of OFDM symbols.
- Forces the scrambled tail bits to zero.
- Sits between the MAC byte interface and the convolutional encoder. Emits one bit per clock, with no stall.

---
 rtl/scr_ctrl_pkg.sv | 19 +
 rtl/scr_byte_fifo.sv | 52 +++++
 rtl/scrambler_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_scrambler_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/scr_ctrl_pkg.sv
// Shared definitions for the 802.11a DATA-field scrambler controller:
// FSM state encoding, field lengths and the reset seed.
package scr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SERVICE,
        ST_DATA,
        ST_TAIL,
        ST_PAD,
        ST_DONE
    } state_e;

    localparam int         SERVICE_BITS = 16;
    localparam int         TAIL_BITS    = 6;
    localparam logic [6:0] DEFAULT_SEED = 7'h7F;

endpackage

// File: rtl/scr_byte_fifo.sv
// Two-entry, 8-bit byte buffer between the MAC byte interface and the
// bit sequencer; head is visible combinationally from the storage flops.
module scr_byte_fifo (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);

    logic [7:0] mem_q [0:1];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/scrambler_ctrl.sv
// Sequences one 802.11a DATA field per request: seed load, SERVICE zeros,
// PSDU bits LSB first, zeroed tail and pad up to a whole OFDM symbol.
module scrambler_ctrl
    import scr_ctrl_pkg::*;
#(
    parameter int LEN_W   = 12,
    parameter int NDBPS_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [NDBPS_W-1:0] ndbps_i,
    input  logic [6:0]         seed_i,
    input  logic [7:0]         byte_i,
    input  logic               byte_valid_i,
    output logic               byte_ready_o,
    output logic               scr_start_o,
    output logic [6:0]         scr_seed_o,
    output logic               scr_x_o,
    input  logic               scr_y_i,
    output logic               bit_o,
    output logic               bit_valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [NDBPS_W-1:0] ndbps_q;
    logic [6:0]         seed_q;
    logic [LEN_W-1:0]   byte_cnt_q;
    logic [LEN_W-1:0]   fetched_q;
    logic [2:0]         bit_cnt_q;
    logic [3:0]         stage_q;
    logic [NDBPS_W-1:0] sym_q;
    logic               busy_q;
    logic               scr_start_q;
    logic               bit_q;
    logic               bit_valid_q;
    logic               done_q;
    logic               err_q;

    logic [7:0]         fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               byte_push;
    logic               byte_pop;
    logic [1:0]         fifo_level;
    logic [1:0]         level_d;
    logic               last_bit;
    logic               last_byte;
    logic               need_byte;
    logic               underrun;
    logic               sym_last;
    logic [NDBPS_W-1:0] sym_d;

    assign byte_ready_o = busy_q && (state_q == ST_SERVICE || state_q == ST_DATA)
                          && (fetched_q < len_q) && !fifo_full;
    assign byte_push    = byte_valid_i && byte_ready_o;

    assign last_bit  = (state_q == ST_DATA) && (bit_cnt_q == 3'd7);
    assign last_byte = (byte_cnt_q == len_q - LEN_W'(1));
    assign byte_pop  = last_bit;

    // Look one cycle ahead: a byte must already sit in the buffer on the
    // cycle its bit 0 is scrambled, otherwise the frame is aborted.
    assign fifo_level = fifo_full ? 2'd2 : {1'b0, !fifo_empty};
    assign level_d    = fifo_level + {1'b0, byte_push} - {1'b0, byte_pop};
    assign need_byte  = (state_q == ST_SERVICE && stage_q == 4'(SERVICE_BITS - 1)
                         && len_q != '0)
                        || (last_bit && !last_byte);
    assign underrun   = need_byte && (level_d == 2'd0);

    assign sym_last = (sym_q == ndbps_q - NDBPS_W'(1));
    assign sym_d    = sym_last ? '0 : sym_q + NDBPS_W'(1);

    assign scr_x_o     = (state_q == ST_DATA) ? fifo_head[bit_cnt_q] : 1'b0;
    assign scr_start_o = scr_start_q;
    assign scr_seed_o  = seed_q;
    assign bit_o       = bit_q;
    assign bit_valid_o = bit_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

    scr_byte_fifo u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (underrun),
        .push_i  (byte_push),
        .data_i  (byte_i),
        .pop_i   (byte_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            ndbps_q     <= '0;
            seed_q      <= DEFAULT_SEED;
            byte_cnt_q  <= '0;
            fetched_q   <= '0;
            bit_cnt_q   <= '0;
            stage_q     <= '0;
            sym_q       <= '0;
            busy_q      <= 1'b0;
            scr_start_q <= 1'b0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bit_valid_q <= scr_start_q;
            bit_q       <= scr_start_q && (state_q != ST_TAIL) && scr_y_i;
            if (scr_start_q) sym_q <= sym_d;
            if (byte_push)   fetched_q <= fetched_q + LEN_W'(1);

            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        if (ndbps_i == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            len_q     <= len_i;
                            ndbps_q   <= ndbps_i;
                            seed_q    <= seed_i;
                            fetched_q <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    stage_q     <= '0;
                    sym_q       <= '0;
                    scr_start_q <= 1'b1;
                    state_q     <= ST_SERVICE;
                end
                ST_SERVICE: begin
                    stage_q <= stage_q + 4'd1;
                    if (stage_q == 4'(SERVICE_BITS - 1)) begin
                        stage_q <= '0;
                        if (len_q == '0) begin
                            state_q <= ST_TAIL;
                        end else if (underrun) begin
                            err_q       <= 1'b1;
                            busy_q      <= 1'b0;
                            scr_start_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            bit_cnt_q  <= '0;
                            byte_cnt_q <= '0;
                            state_q    <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        if (last_byte) begin
                            stage_q <= '0;
                            state_q <= ST_TAIL;
                        end else if (underrun) begin
                            err_q       <= 1'b1;
                            busy_q      <= 1'b0;
                            scr_start_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + LEN_W'(1);
                        end
                    end
                end
                ST_TAIL: begin
                    stage_q <= stage_q + 4'd1;
                    if (stage_q == 4'(TAIL_BITS - 1)) begin
                        if (sym_d == '0) begin
                            scr_start_q <= 1'b0;
                            state_q     <= ST_DONE;
                        end else begin
                            state_q <= ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    if (sym_last) begin
                        scr_start_q <= 1'b0;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    scr_start_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scrambler_ctrl.sv
// Directed bench for scrambler_ctrl with an x^7+x^4+1 scrambler beside it.
module tb_scrambler_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [11:0] len = '0;
    logic [7:0]  ndbps = '0;
    logic [6:0]  seed = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready, scr_start, scr_x, scr_y, bit_out, bit_valid;
    logic        busy, done, err;
    logic [6:0]  scr_seed;

    always #5 clk = ~clk;

    scrambler_ctrl #(.LEN_W(12), .NDBPS_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .len_i(len), .ndbps_i(ndbps),
        .seed_i(seed), .byte_i(byte_in), .byte_valid_i(byte_valid),
        .byte_ready_o(byte_ready), .scr_start_o(scr_start), .scr_seed_o(scr_seed),
        .scr_x_o(scr_x), .scr_y_i(scr_y), .bit_o(bit_out), .bit_valid_o(bit_valid),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    // Scrambler: Start=0 loads the seed, Start=1 shifts the feedback in.
    logic [6:0] scr_s = 7'h7F;
    always @(posedge clk) begin
        if (!scr_start) scr_s <= scr_seed;
        else            scr_s <= {scr_s[5:0], scr_s[6] ^ scr_s[3]};
    end
    assign scr_y = scr_x ^ scr_s[6] ^ scr_s[3];

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0]  frame_bytes [0:15];
    logic [7:0]  src[$];
    logic        got_bits[$];
    logic        exp_bits[$];
    logic [23:0] got_vec;
    int first_v, last_v, gaps, done_cyc, done_cnt, err_cyc, err_cnt, hs_cnt, hs_first;
    logic busy_end, finished;

    // Drives one frame from the negedge before the accept edge (cycle 0);
    // everything is sampled on negedges, indexed by cycle number.
    task automatic run_frame(input logic [6:0] sd, input int ln, input int nd,
                             input int n_offer, input int extra_req_at, input int rst_at);
        int end_at;
        src.delete();
        for (int i = 0; i < n_offer; i++) src.push_back(frame_bytes[i]);
        got_bits.delete();
        got_vec = '0;
        first_v = -1; last_v = -1; gaps = 0;
        done_cyc = -1; done_cnt = 0; err_cyc = -1; err_cnt = 0;
        hs_cnt = 0; hs_first = -1; busy_end = 1'bx; finished = 1'b0;
        end_at = -1;
        @(negedge clk);
        req = 1'b1; len = 12'(ln); ndbps = 8'(nd); seed = sd;
        byte_valid = (src.size() > 0);
        byte_in = byte_valid ? src[0] : 8'h00;
        for (int rel = 1; rel <= 2000; rel++) begin
            @(negedge clk);
            req = 1'b0;
            if (rel == extra_req_at) begin
                req = 1'b1; seed = 7'h01; len = 12'd0; ndbps = 8'd96;
            end
            if (rel == rst_at) begin
                rst_n = 1'b0;
                finished = 1'b1;
                break;
            end
            if (bit_valid) begin
                if (last_v >= 0 && last_v != rel - 1) gaps++;
                if (first_v < 0) first_v = rel;
                last_v = rel;
                got_bits.push_back(bit_out);
                got_vec = {got_vec[22:0], bit_out};
            end
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = rel; end
            if (err)  begin err_cnt++;  err_cyc = rel; end
            byte_valid = (src.size() > 0);
            byte_in = byte_valid ? src[0] : 8'h00;
            if (byte_valid && byte_ready) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = rel;
                void'(src.pop_front());
            end
            if (rel == end_at) begin
                busy_end = busy;
                finished = 1'b1;
                break;
            end
            if (end_at < 0 && (done_cnt > 0 || err_cnt > 0)) end_at = rel + 1;
        end
        req = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic build_exp(input logic [6:0] sd, input int ln, input int nd);
        int total, n;
        logic [6:0] s;
        logic x, fb, y;
        exp_bits.delete();
        total = 22 + 8 * ln;
        n = ((total + nd - 1) / nd) * nd;
        s = sd;
        for (int i = 0; i < n; i++) begin
            x = 1'b0;
            if (i >= 16 && i < 16 + 8 * ln) x = frame_bytes[(i - 16) / 8][(i - 16) % 8];
            fb = s[6] ^ s[3];
            y = x ^ fb;
            s = {s[5:0], fb};
            if (i >= 16 + 8 * ln && i < 22 + 8 * ln) y = 1'b0;
            exp_bits.push_back(y);
        end
    endtask

    task automatic cmp_bits(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < exp_bits.size(); i++)
            if (i >= got_bits.size() || got_bits[i] !== exp_bits[i]) mism++;
        chk({tag, "_nbits"}, got_bits.size(), exp_bits.size());
        chk({tag, "_bit_mismatches"}, mism, 0);
    endtask

    initial begin
        logic orv;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {scr_start, scr_x, bit_out, bit_valid, byte_ready, busy, done, err, scr_seed},
            32'h0000_007F);
        rst_n = 1'b1;
        @(negedge clk);

        // Len=0, Ndbps=24, all-ones seed
        run_frame(7'h7F, 0, 24, 0, 0, 0);
        $display("[TB] frame len=0 ndbps=24: bits=%0d first=%0d last=%0d done=%0d", got_bits.size(), first_v, last_v, done_cyc);
        chk("t1_finished", finished, 1);
        chk("t1_first_valid", first_v, 3);
        chk("t1_last_valid", last_v, 26);
        chk("t1_bits", got_vec, 24'b0000_1110_1111_0010_0000_0001);
        chk("t1_done_cycle", done_cyc, 27);
        chk("t1_done_count", done_cnt, 1);
        chk("t1_busy_after", busy_end, 0);
        chk("t1_err", err_cnt, 0);

        // Len=1, byte A5
        frame_bytes[0] = 8'hA5;
        run_frame(7'h5D, 1, 24, 1, 0, 0);
        $display("[TB] frame len=1 ndbps=24: bits=%0d gaps=%0d done=%0d", got_bits.size(), gaps, done_cyc);
        build_exp(7'h5D, 1, 24);
        cmp_bits("t2");
        orv = 1'b0;
        for (int i = 24; i < 30 && i < got_bits.size(); i++) orv |= got_bits[i];
        chk("t2_tail_zero", orv, 0);
        chk("t2_gaps", gaps, 0);
        chk("t2_done_count", done_cnt, 1);

        // Len=3: prefetch during SERVICE, two pad bits
        frame_bytes[0] = 8'h3C; frame_bytes[1] = 8'h0F; frame_bytes[2] = 8'hE1;
        run_frame(7'h2A, 3, 24, 3, 0, 0);
        $display("[TB] frame len=3 ndbps=24: bits=%0d handshakes=%0d first_hs=%0d", got_bits.size(), hs_cnt, hs_first);
        build_exp(7'h2A, 3, 24);
        cmp_bits("t3");
        chk("t3_gaps", gaps, 0);
        chk("t3_handshakes", hs_cnt, 3);
        chk("t3_first_hs_in_service", (hs_first >= 2 && hs_first <= 17), 1);
        chk("t3_done_count", done_cnt, 1);

        // Len=2 with only one byte offered: underrun
        frame_bytes[0] = 8'h11; frame_bytes[1] = 8'h22;
        run_frame(7'h4C, 2, 24, 1, 0, 0);
        $display("[TB] underrun len=2: err_cycle=%0d last_valid=%0d done=%0d", err_cyc, last_v, done_cnt);
        chk("t4_finished", finished, 1);
        chk("t4_err_cycle", err_cyc, 26);
        chk("t4_err_count", err_cnt, 1);
        chk("t4_last_valid", last_v, 26);
        chk("t4_busy_after", busy_end, 0);
        chk("t4_no_done", done_cnt, 0);

        // Asynchronous reset in the middle of DATA
        frame_bytes[0] = 8'h01; frame_bytes[1] = 8'h80; frame_bytes[2] = 8'hFF; frame_bytes[3] = 8'h5A;
        run_frame(7'h33, 4, 48, 4, 0, 22);
        #1;
        $display("[TB] reset asserted mid-DATA");
        chk("t5_reset_outputs", {scr_start, scr_x, bit_out, bit_valid, byte_ready, busy, done, err, scr_seed},
            32'h0000_007F);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(7'h33, 4, 48, 4, 0, 0);
        $display("[TB] frame after reset len=4 ndbps=48: bits=%0d done=%0d", got_bits.size(), done_cyc);
        build_exp(7'h33, 4, 48);
        cmp_bits("t5");
        chk("t5_gaps", gaps, 0);
        chk("t5_done_count", done_cnt, 1);

        // Ndbps=0 is rejected
        @(negedge clk);
        req = 1'b1; ndbps = 8'd0; len = 12'd5;
        @(negedge clk);
        req = 1'b0;
        $display("[TB] req ndbps=0: err=%0b busy=%0b", err, busy);
        chk("t6_err_pulse", err, 1);
        chk("t6_busy", busy, 0);
        @(negedge clk);
        chk("t6_err_single", err, 0);
        chk("t6_busy_still_low", busy, 0);

        // Second Req while busy is ignored
        frame_bytes[0] = 8'hA5;
        run_frame(7'h7F, 1, 24, 1, 10, 0);
        $display("[TB] frame with extra req: bits=%0d err=%0d done=%0d", got_bits.size(), err_cnt, done_cnt);
        build_exp(7'h7F, 1, 24);
        cmp_bits("t7");
        chk("t7_no_err", err_cnt, 0);
        chk("t7_done_count", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
